// File: rtl/image_convert_pkg.sv
`default_nettype none
// ============================================================================
// Module   : image_convert_pkg
// Brief    : Image-spec type, format codes, luma coefficients, frame states
//            and field-layout helpers shared by the image_convert block.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef IMAGE_CONVERT_DEFS_SVH
`define IMAGE_CONVERT_DEFS_SVH
`define IS_FORMAT_GRAY 2'd0
`define IS_FORMAT_RGB  2'd1
`define I_CONVERT_OK(IIS, OIS) \
    ((((IIS).format == `IS_FORMAT_GRAY) || ((IIS).format == `IS_FORMAT_RGB)) && \
     (((OIS).format == `IS_FORMAT_GRAY) || ((OIS).format == `IS_FORMAT_RGB)))
`endif

package image_convert_pkg;

    // Field widths; pixel data packs c0 at the LSBs, then c1, c2, alpha, z.
    typedef struct packed {
        logic [1:0] format;
        logic [7:0] c0_w;
        logic [7:0] c1_w;
        logic [7:0] c2_w;
        logic [7:0] a_w;
        logic [7:0] z_w;
    } image_spec_t;

    localparam logic [1:0] FMT_GRAY = `IS_FORMAT_GRAY;
    localparam logic [1:0] FMT_RGB  = `IS_FORMAT_RGB;

    localparam int LUMA_R     = 77;
    localparam int LUMA_G     = 150;
    localparam int LUMA_B     = 29;
    localparam int LUMA_SHIFT = 8;
    localparam int NORM_W     = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    function automatic image_spec_t is_make(input logic [1:0] fmt, input int c0,
                                            input int c1, input int c2,
                                            input int a, input int z);
        image_spec_t s;
        s.format = fmt;
        s.c0_w   = 8'(c0);
        s.c1_w   = 8'(c1);
        s.c2_w   = 8'(c2);
        s.a_w    = 8'(a);
        s.z_w    = 8'(z);
        return s;
    endfunction

    // idx: 0..2 colour channels, 3 alpha, 4 z
    function automatic int is_chan_w(input image_spec_t s, input int idx);
        case (idx)
            0:       return int'(s.c0_w);
            1:       return int'(s.c1_w);
            2:       return int'(s.c2_w);
            3:       return int'(s.a_w);
            default: return int'(s.z_w);
        endcase
    endfunction

    function automatic int is_chan_off(input image_spec_t s, input int idx);
        int off = 0;
        for (int k = 0; k < idx; k++) begin
            off += is_chan_w(s, k);
        end
        return off;
    endfunction

    function automatic int is_data_w(input image_spec_t s);
        return is_chan_off(s, 5);
    endfunction

    localparam image_spec_t IS_DEFAULT = is_make(FMT_RGB, 8, 8, 8, 0, 0);

endpackage

`default_nettype wire

// File: rtl/image_channel_scale.sv
`default_nettype none
// ============================================================================
// Module   : image_channel_scale
// Brief    : Combinational channel width rescale: MSB truncation when
//            narrowing, zero pad or cyclic MSB replication when widening.
// Revision : 1.0 - initial release
// ============================================================================

module image_channel_scale #(
    parameter int W_IN      = 8,
    parameter int W_OUT     = 8,
    parameter int REPLICATE = 1
) (
    input  logic [W_IN-1:0]  i_data,
    output logic [W_OUT-1:0] o_data
);

    logic w_unused_in;
    assign w_unused_in = ^i_data;

    // Output bit k counted from the MSB copies input bit k (mod W_IN) from the MSB.
    for (genvar k = 0; k < W_OUT; k++) begin : g_bit
        if (k < W_IN) begin : g_copy
            assign o_data[W_OUT-1-k] = i_data[W_IN-1-k];
        end else if (REPLICATE != 0) begin : g_rep
            assign o_data[W_OUT-1-k] = i_data[W_IN-1-(k % W_IN)];
        end else begin : g_pad
            assign o_data[W_OUT-1-k] = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/image_convert.sv
`default_nettype none
// ============================================================================
// Module   : image_convert
// Brief    : Registered gray/RGB pixel converter with framing checks.
//            Optional alpha/Z handling under IMAGE_CONVERT_ALPHA_EN.
// Revision : 1.0 - initial release
// ============================================================================

module image_convert
    import image_convert_pkg::*;
#(
    parameter image_spec_t IN_IS     = IS_DEFAULT,
    parameter image_spec_t OUT_IS    = IS_DEFAULT,
    parameter int          REPLICATE = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          image_in_start,
    input  logic                          image_in_stop,
    input  logic                          image_in_valid,
    input  logic                          image_in_error,
    input  logic [is_data_w(IN_IS)-1:0]   image_in_data,
    output logic                          image_in_ready,
    output logic                          image_in_request,
    output logic                          image_in_cancel,
    output logic                          image_out_start,
    output logic                          image_out_stop,
    output logic                          image_out_valid,
    output logic                          image_out_error,
    output logic [is_data_w(OUT_IS)-1:0]  image_out_data,
    input  logic                          image_out_ready,
    input  logic                          image_out_request,
    input  logic                          image_out_cancel
);

    localparam int   OUT_DW     = is_data_w(OUT_IS);
    localparam logic CONVERT_OK = `I_CONVERT_OK(IN_IS, OUT_IS);

    logic [OUT_DW-1:0] w_conv;
    logic              w_xfer;
    logic              w_proto_err;
    logic              w_unused_data;

    logic [0:0]        state_q, state_d;
    logic              valid_q, valid_d;
    logic              start_q, start_d;
    logic              stop_q, stop_d;
    logic              error_q, error_d;
    logic [OUT_DW-1:0] data_q, data_d;

    assign w_unused_data    = ^image_in_data;
    assign image_in_request = image_out_request;
    assign image_in_cancel  = image_out_cancel;
    assign image_in_ready   = image_out_ready | ~valid_q;
    assign w_xfer           = image_in_valid & image_in_ready;

    // ------------------------------------------------------------------
    // Pixel conversion
    // ------------------------------------------------------------------
    if (!CONVERT_OK) begin : g_unsupported
        assign w_conv = '0;
    end else begin : g_supported
        if (OUT_IS.format == FMT_GRAY) begin : g_to_gray
            if (IN_IS.format == FMT_GRAY) begin : g_gray
                image_channel_scale #(
                    .W_IN      (is_chan_w(IN_IS, 0)),
                    .W_OUT     (is_chan_w(OUT_IS, 0)),
                    .REPLICATE (REPLICATE)
                ) u_scale (
                    .i_data (image_in_data[0 +: is_chan_w(IN_IS, 0)]),
                    .o_data (w_conv[0 +: is_chan_w(OUT_IS, 0)])
                );
            end else begin : g_luma
                logic [NORM_W-1:0] w_rgb8 [3];
                logic [15:0]       w_acc;
                logic [NORM_W-1:0] w_y8;

                // Channels are always normalised with replication so full scale stays full scale.
                for (genvar c = 0; c < 3; c++) begin : g_norm
                    image_channel_scale #(
                        .W_IN      (is_chan_w(IN_IS, c)),
                        .W_OUT     (NORM_W),
                        .REPLICATE (1)
                    ) u_norm (
                        .i_data (image_in_data[is_chan_off(IN_IS, c) +: is_chan_w(IN_IS, c)]),
                        .o_data (w_rgb8[c])
                    );
                end

                assign w_acc = 16'(LUMA_R) * 16'(w_rgb8[0])
                             + 16'(LUMA_G) * 16'(w_rgb8[1])
                             + 16'(LUMA_B) * 16'(w_rgb8[2]);
                assign w_y8  = NORM_W'(w_acc >> LUMA_SHIFT);

                image_channel_scale #(
                    .W_IN      (NORM_W),
                    .W_OUT     (is_chan_w(OUT_IS, 0)),
                    .REPLICATE (REPLICATE)
                ) u_y (
                    .i_data (w_y8),
                    .o_data (w_conv[0 +: is_chan_w(OUT_IS, 0)])
                );
            end
        end else begin : g_to_rgb
            for (genvar c = 0; c < 3; c++) begin : g_chan
                localparam int SRC_C = (IN_IS.format == FMT_GRAY) ? 0 : c;
                image_channel_scale #(
                    .W_IN      (is_chan_w(IN_IS, SRC_C)),
                    .W_OUT     (is_chan_w(OUT_IS, c)),
                    .REPLICATE (REPLICATE)
                ) u_scale (
                    .i_data (image_in_data[is_chan_off(IN_IS, SRC_C) +: is_chan_w(IN_IS, SRC_C)]),
                    .o_data (w_conv[is_chan_off(OUT_IS, c) +: is_chan_w(OUT_IS, c)])
                );
            end
        end

`ifdef IMAGE_CONVERT_ALPHA_EN
        if (is_chan_w(OUT_IS, 3) > 0) begin : g_alpha
            if (is_chan_w(IN_IS, 3) > 0) begin : g_scale
                image_channel_scale #(
                    .W_IN      (is_chan_w(IN_IS, 3)),
                    .W_OUT     (is_chan_w(OUT_IS, 3)),
                    .REPLICATE (REPLICATE)
                ) u_alpha (
                    .i_data (image_in_data[is_chan_off(IN_IS, 3) +: is_chan_w(IN_IS, 3)]),
                    .o_data (w_conv[is_chan_off(OUT_IS, 3) +: is_chan_w(OUT_IS, 3)])
                );
            end else begin : g_opaque
                assign w_conv[is_chan_off(OUT_IS, 3) +: is_chan_w(OUT_IS, 3)] = '1;
            end
        end
        if (is_chan_w(OUT_IS, 4) > 0) begin : g_z
            if (is_chan_w(IN_IS, 4) > 0) begin : g_pass
                image_channel_scale #(
                    .W_IN      (is_chan_w(IN_IS, 4)),
                    .W_OUT     (is_chan_w(OUT_IS, 4)),
                    .REPLICATE (0)
                ) u_z (
                    .i_data (image_in_data[is_chan_off(IN_IS, 4) +: is_chan_w(IN_IS, 4)]),
                    .o_data (w_conv[is_chan_off(OUT_IS, 4) +: is_chan_w(OUT_IS, 4)])
                );
            end else begin : g_zero
                assign w_conv[is_chan_off(OUT_IS, 4) +: is_chan_w(OUT_IS, 4)] = '0;
            end
        end
`else
        if (is_chan_w(OUT_IS, 3) > 0) begin : g_alpha
            assign w_conv[is_chan_off(OUT_IS, 3) +: is_chan_w(OUT_IS, 3)] = '0;
        end
        if (is_chan_w(OUT_IS, 4) > 0) begin : g_z
            assign w_conv[is_chan_off(OUT_IS, 4) +: is_chan_w(OUT_IS, 4)] = '0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start seen inside a frame simply restarts it; any stop closes it.
    always_comb begin
        state_d = state_q;
        if (image_out_cancel) begin
            state_d = ST_IDLE;
        end else if (w_xfer) begin
            if (image_in_stop) begin
                state_d = ST_IDLE;
            end else if (image_in_start) begin
                state_d = ST_FRAME;
            end
        end
    end

    always_comb begin
        w_proto_err = 1'b0;
        case (state_q)
            ST_IDLE:  w_proto_err = ~image_in_start;
            ST_FRAME: w_proto_err = image_in_start;
            default:  w_proto_err = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        start_d = start_q;
        stop_d  = stop_q;
        error_d = error_q;
        data_d  = data_q;
        if (image_out_cancel) begin
            valid_d = 1'b0;
        end else if (w_xfer) begin
            valid_d = 1'b1;
            start_d = image_in_start;
            stop_d  = image_in_stop;
            error_d = image_in_error | w_proto_err | ~CONVERT_OK;
            data_d  = w_conv;
        end else if (image_out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            error_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            error_q <= error_d;
            data_q  <= data_d;
        end
    end

    assign image_out_valid = valid_q;
    assign image_out_start = start_q;
    assign image_out_stop  = stop_q;
    assign image_out_error = error_q;
    assign image_out_data  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_image_convert.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_convert
// Brief    : Directed self-checking bench for image_convert (conversions,
//            back-pressure, framing, cancel, asynchronous reset).
// Revision : 1.0 - initial release
// ============================================================================

module tb_image_convert;
    import image_convert_pkg::*;

    localparam image_spec_t IS_G4  = is_make(FMT_GRAY, 4, 0, 0, 0, 0);
    localparam image_spec_t IS_G8  = is_make(FMT_GRAY, 8, 0, 0, 0, 0);
    localparam image_spec_t IS_565 = is_make(FMT_RGB, 5, 6, 5, 0, 0);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_start = 1'b0, in_stop = 1'b0, in_valid = 1'b0, in_error = 1'b0;
    logic out_ready = 1'b1, out_request = 1'b0, out_cancel = 1'b0;
    logic [3:0]  d4  = '0;
    logic [15:0] d16 = '0;
    logic [23:0] d24 = '0;

    logic m_in_ready, m_in_request, m_in_cancel, m_out_start, m_out_stop, m_out_valid, m_out_error;
    logic a_in_ready, a_in_request, a_in_cancel, a_out_start, a_out_stop, a_out_valid, a_out_error;
    logic b_in_ready, b_in_request, b_in_cancel, b_out_start, b_out_stop, b_out_valid, b_out_error;
    logic c_in_ready, c_in_request, c_in_cancel, c_out_start, c_out_stop, c_out_valid, c_out_error;
    logic [23:0] m_out_data;
    logic [15:0] a_out_data, b_out_data;
    logic [7:0]  c_out_data;

    int n_cmp = 0;
    int n_err = 0;
    int sent, got;
    logic did_in, did_out, held;
    logic [23:0] held_data;

    always #5 clk = ~clk;

    image_convert u_main (
        .clock(clk), .reset(rst),
        .image_in_start(in_start), .image_in_stop(in_stop), .image_in_valid(in_valid),
        .image_in_error(in_error), .image_in_data(d24), .image_in_ready(m_in_ready),
        .image_in_request(m_in_request), .image_in_cancel(m_in_cancel),
        .image_out_start(m_out_start), .image_out_stop(m_out_stop), .image_out_valid(m_out_valid),
        .image_out_error(m_out_error), .image_out_data(m_out_data), .image_out_ready(out_ready),
        .image_out_request(out_request), .image_out_cancel(out_cancel)
    );

    image_convert #(.IN_IS(IS_G4), .OUT_IS(IS_565), .REPLICATE(1)) u_g2c_rep (
        .clock(clk), .reset(rst),
        .image_in_start(in_start), .image_in_stop(in_stop), .image_in_valid(in_valid),
        .image_in_error(in_error), .image_in_data(d4), .image_in_ready(a_in_ready),
        .image_in_request(a_in_request), .image_in_cancel(a_in_cancel),
        .image_out_start(a_out_start), .image_out_stop(a_out_stop), .image_out_valid(a_out_valid),
        .image_out_error(a_out_error), .image_out_data(a_out_data), .image_out_ready(out_ready),
        .image_out_request(out_request), .image_out_cancel(out_cancel)
    );

    image_convert #(.IN_IS(IS_G4), .OUT_IS(IS_565), .REPLICATE(0)) u_g2c_pad (
        .clock(clk), .reset(rst),
        .image_in_start(in_start), .image_in_stop(in_stop), .image_in_valid(in_valid),
        .image_in_error(in_error), .image_in_data(d4), .image_in_ready(b_in_ready),
        .image_in_request(b_in_request), .image_in_cancel(b_in_cancel),
        .image_out_start(b_out_start), .image_out_stop(b_out_stop), .image_out_valid(b_out_valid),
        .image_out_error(b_out_error), .image_out_data(b_out_data), .image_out_ready(out_ready),
        .image_out_request(out_request), .image_out_cancel(out_cancel)
    );

    image_convert #(.IN_IS(IS_565), .OUT_IS(IS_G8), .REPLICATE(1)) u_c2g (
        .clock(clk), .reset(rst),
        .image_in_start(in_start), .image_in_stop(in_stop), .image_in_valid(in_valid),
        .image_in_error(in_error), .image_in_data(d16), .image_in_ready(c_in_ready),
        .image_in_request(c_in_request), .image_in_cancel(c_in_cancel),
        .image_out_start(c_out_start), .image_out_stop(c_out_stop), .image_out_valid(c_out_valid),
        .image_out_error(c_out_error), .image_out_data(c_out_data), .image_out_ready(out_ready),
        .image_out_request(out_request), .image_out_cancel(out_cancel)
    );

    // Conversion vectors: RGB565 packed as {B5, G6, R5}
    localparam logic [3:0]  CV_G4  [4] = '{4'hA, 4'h5, 4'hF, 4'h0};
    localparam logic [15:0] CV_REP [4] = '{{5'h15, 6'h2A, 5'h15}, {5'h0A, 6'h15, 5'h0A},
                                           {5'h1F, 6'h3F, 5'h1F}, 16'h0000};
    localparam logic [15:0] CV_PAD [4] = '{{5'h14, 6'h28, 5'h14}, {5'h0A, 6'h14, 5'h0A},
                                           {5'h1E, 6'h3C, 5'h1E}, 16'h0000};
    localparam logic [15:0] CV_RGB [4] = '{{5'h1F, 6'h3F, 5'h1F}, {5'h00, 6'h00, 5'h1F},
                                           16'h0000, {5'h00, 6'h3F, 5'h00}};
    localparam logic [7:0]  CV_Y   [4] = '{8'd255, 8'd76, 8'd0, 8'd149};
    localparam logic [23:0] CV_P24 [4] = '{24'h123456, 24'hFEDCBA, 24'h000000, 24'hA5A5A5};

    // Framing vectors: {start, stop, in_error, expected out_error}
    localparam logic [3:0]  FR [8] = '{4'b1000, 4'b0000, 4'b0000, 4'b1001,
                                       4'b0100, 4'b0001, 4'b1100, 4'b1111};

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic e, input logic err,
                        input logic [23:0] p24);
        in_valid = v;
        in_start = s;
        in_stop  = e;
        in_error = err;
        d24      = p24;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] pix(input int i);
        return 24'(32'h00A0_0000 + i * 32'h0001_0203);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", m_out_valid, 1'b0);
        chk("rst_start", m_out_start, 1'b0);
        chk("rst_stop", m_out_stop, 1'b0);
        chk("rst_error", m_out_error, 1'b0);
        chk("rst_data", m_out_data, 24'h0);
        chk("rst_in_ready", m_in_ready, 1'b1);
        chk("rst_c2g_data", c_out_data, 8'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-pixel frames through every converter
        for (int i = 0; i < 4; i++) begin
            d4  = CV_G4[i];
            d16 = CV_RGB[i];
            step(1'b1, 1'b1, 1'b1, 1'b0, CV_P24[i]);
            chk("cv_valid", a_out_valid, 1'b1);
            chk("cv_g2c_rep", a_out_data, CV_REP[i]);
            chk("cv_g2c_pad", b_out_data, CV_PAD[i]);
            chk("cv_c2g_y", c_out_data, CV_Y[i]);
            chk("cv_c2g_err", c_out_error, 1'b0);
            chk("cv_rgb888", m_out_data, CV_P24[i]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        chk("cv_drain", m_out_valid, 1'b0);

        // Back-pressure: 8-pixel frame, out_ready low for three cycles
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 6);
            in_valid  = (sent < 8);
            in_start  = (sent == 0);
            in_stop   = (sent == 7);
            in_error  = 1'b0;
            d24       = pix(sent);
            #1;
            if (m_out_valid && !out_ready) chk("bp_in_ready", m_in_ready, 1'b0);
            did_in    = in_valid && m_in_ready;
            did_out   = m_out_valid && out_ready;
            held      = m_out_valid && !out_ready;
            held_data = m_out_data;
            if (did_out) begin
                chk("bp_data", m_out_data, pix(got));
                chk("bp_err", m_out_error, 1'b0);
                got++;
            end
            @(posedge clk);
            #1;
            if (did_in) sent++;
            if (held) begin
                chk("bp_hold_valid", m_out_valid, 1'b1);
                chk("bp_hold_data", m_out_data, held_data);
            end
        end
        chk("bp_count", got, 8);
        out_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        chk("bp_drain", m_out_valid, 1'b0);

        // Framing errors
        for (int i = 0; i < 8; i++) begin
            step(1'b1, FR[i][3], FR[i][2], FR[i][1], pix(i));
            chk("fr_valid", m_out_valid, 1'b1);
            chk("fr_start", m_out_start, FR[i][3]);
            chk("fr_error", m_out_error, FR[i][0]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);

        // Cancel while stalled, then cancel racing a transfer
        out_ready = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'h111111);
        chk("cx_held", m_out_valid, 1'b1);
        out_cancel = 1'b1;
        in_valid   = 1'b0;
        #1;
        chk("cx_in_cancel", m_in_cancel, 1'b1);
        @(posedge clk);
        #1;
        chk("cx_cleared", m_out_valid, 1'b0);
        out_cancel = 1'b0;
        out_ready  = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'h222222);
        chk("cx_restart_valid", m_out_valid, 1'b1);
        chk("cx_restart_err", m_out_error, 1'b0);
        out_cancel = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'h333333);
        chk("cx_drop", m_out_valid, 1'b0);
        out_cancel = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b0, 24'h444444);
        chk("cx_idle_err", m_out_error, 1'b0);
        chk("cx_idle_data", m_out_data, 24'h444444);
        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);

        out_request = 1'b1;
        #1;
        chk("req_hi", m_in_request, 1'b1);
        out_request = 1'b0;
        #1;
        chk("req_lo", m_in_request, 1'b0);

        // Asynchronous reset mid-frame
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'h5A5A5A);
        chk("ar_pre_valid", m_out_valid, 1'b1);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("ar_valid", m_out_valid, 1'b0);
        chk("ar_data", m_out_data, 24'h0);
        chk("ar_start", m_out_start, 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'h777777);
        chk("ar_first_valid", m_out_valid, 1'b1);
        chk("ar_first_err", m_out_error, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 24'h888888);
        chk("ar_stop_err", m_out_error, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        chk("ar_drain", m_out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
